// File: rtl/selftest_pkg.sv
// Shared definitions for the power-on self-test sequencer: the sequencer
// states, the {R,G} colour codes and the seven-segment digit nibbles.
package selftest_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] COLOR_OFF    = 2'b00;
    localparam logic [1:0] COLOR_GREEN  = 2'b01;
    localparam logic [1:0] COLOR_RED    = 2'b10;
    localparam logic [1:0] COLOR_YELLOW = 2'b11;

    localparam logic [3:0] DIGIT_ALL   = 4'h8;
    localparam logic [3:0] DIGIT_BLANK = 4'hf;

endpackage

// File: rtl/phase_timer.sv
// Blink phase timer: counts clk cycles through one full blink period
// (on half followed by off half) and flags the last cycle of the period.
module phase_timer #(
    parameter int PHASE_CYCLES = 25_000_000
) (
    input  logic clk,
    input  logic sw,
    input  logic clr,
    input  logic en,
    output logic blink,
    output logic step_end
);

    localparam int PC_W = $clog2(2 * PHASE_CYCLES);
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(2 * PHASE_CYCLES - 1);
    localparam logic [PC_W-1:0] PC_HALF = PC_W'(PHASE_CYCLES);

    logic [PC_W-1:0] r_pc;

    // Phase counter: cleared by reset or clr, otherwise advances when enabled and wraps at period end
    always_ff @(posedge clk or negedge sw) begin
        if (!sw) begin
            r_pc <= '0;
        end else if (clr) begin
            r_pc <= '0;
        end else if (en) begin
            r_pc <= step_end ? '0 : r_pc + 1'b1;
        end
    end

    assign blink    = (r_pc < PC_HALF);
    assign step_end = (r_pc == PC_LAST);

endmodule

// File: rtl/self_test_seq.sv
// Power-on self-test sequencer: after the main switch is released it walks
// through NUM_STEPS colour steps, blinking the LED matrix, the digit display
// and the buzzer together, then reports completion (or loops forever).
module self_test_seq
    import selftest_pkg::*;
#(
    parameter int                      PHASE_CYCLES = 25_000_000,
    parameter int                      NUM_STEPS    = 3,
    parameter logic [2*NUM_STEPS-1:0]  COLOR_SEQ    = 6'b11_01_10,
    parameter int                      PIXELS       = 64,
    parameter int                      DIGITS       = 8,
    parameter int                      LOOP         = 0
) (
    input  logic                  clk,
    input  logic                  sw,
    input  logic                  restart,
    input  logic                  hold,
    output logic                  finish,
    output logic                  beep_en,
    output logic [2:0]            tone_idx,
    output logic [2*PIXELS-1:0]   matrix_data,
    output logic [4*DIGITS-1:0]   numbers_data
);

    localparam logic [2:0]  LAST_STEP = 3'(NUM_STEPS - 1);
    localparam logic [15:0] SEQ_EXT   = 16'(COLOR_SEQ);

    state_t     r_state;
    state_t     w_nextState;
    logic [2:0] r_step;
    logic [2:0] w_nextStep;
    logic       w_run;
    logic       w_blink;
    logic       w_stepEnd;
    logic       w_clr;
    logic       w_en;
    logic       w_lit;
    logic [1:0] w_color;

    assign w_run = (r_state == RUN);
    assign w_en  = w_run & ~hold;
    assign w_clr = restart | ~w_run;

    phase_timer #(
        .PHASE_CYCLES(PHASE_CYCLES)
    ) u_phaseTimer (
        .clk     (clk),
        .sw      (sw),
        .clr     (w_clr),
        .en      (w_en),
        .blink   (w_blink),
        .step_end(w_stepEnd)
    );

    // State and step registers, forced to IDLE / step 0 while the switch is off
    always_ff @(posedge clk or negedge sw) begin
        if (!sw) begin
            r_state <= IDLE;
            r_step  <= '0;
        end else begin
            r_state <= w_nextState;
            r_step  <= w_nextStep;
        end
    end

    // Next state and step: restart wins over hold and over a step advance
    always_comb begin
        w_nextState = r_state;
        w_nextStep  = r_step;
        if (restart) begin
            w_nextState = RUN;
            w_nextStep  = '0;
        end else if (!hold) begin
            case (r_state)
                IDLE: begin
                    w_nextState = RUN;
                    w_nextStep  = '0;
                end
                RUN: begin
                    if (w_stepEnd) begin
                        if (r_step == LAST_STEP) begin
                            w_nextStep  = '0;
                            w_nextState = (LOOP != 0) ? RUN : DONE;
                        end else begin
                            w_nextStep = r_step + 3'd1;
                        end
                    end
                end
                DONE: begin
                    w_nextState = DONE;
                end
                default: begin
                    w_nextState = IDLE;
                    w_nextStep  = '0;
                end
            endcase
        end
    end

    assign w_lit   = w_run & w_blink;
    assign w_color = SEQ_EXT[{r_step, 1'b0} +: 2] & {2{w_lit}};

    assign matrix_data  = {PIXELS{w_color}};
    assign numbers_data = {DIGITS{w_lit ? DIGIT_ALL : DIGIT_BLANK}};
    assign beep_en      = w_lit;
    assign tone_idx     = r_step;
    assign finish       = (LOOP != 0) ? (w_run & (r_step == LAST_STEP) & w_stepEnd)
                                      : (r_state == DONE);

endmodule

// File: tb/tb_self_test_seq.sv
// Scoreboard bench for self_test_seq: one one-shot and one looping instance
// share the same stimulus; a time-based reference model predicts outputs.
module tb_self_test_seq;

    localparam int PC    = 4;
    localparam int NS    = 3;
    localparam int PIX   = 64;
    localparam int DIG   = 8;
    localparam int TOTAL = 2 * PC * NS;

    logic clk = 1'b0;
    logic sw = 1'b1;
    logic restart = 1'b0;
    logic hold = 1'b0;

    logic fin0, fin1, beep0, beep1;
    logic [2:0] tone0, tone1;
    logic [2*PIX-1:0] mat0, mat1;
    logic [4*DIG-1:0] num0, num1;

    typedef struct {
        logic             finish;
        logic             beep;
        logic [2:0]       tone;
        logic [2*PIX-1:0] matrix;
        logic [4*DIG-1:0] numbers;
    } outs_t;

    typedef struct {
        outs_t e0;
        outs_t e1;
    } exp_t;

    exp_t expQ[$];
    int   passCount = 0;
    int   checkCount = 0;

    bit   idleM [2] = '{1'b1, 1'b1};
    int   tM    [2] = '{0, 0};
    bit   pSw = 1'b0;
    bit   pRs = 1'b0;
    bit   pHd = 1'b0;
    logic [1:0] colorTab [3] = '{2'b10, 2'b01, 2'b11};

    always #5 clk = ~clk;

    self_test_seq #(.PHASE_CYCLES(PC), .NUM_STEPS(NS), .PIXELS(PIX), .DIGITS(DIG), .LOOP(0)) dut0 (
        .clk(clk), .sw(sw), .restart(restart), .hold(hold),
        .finish(fin0), .beep_en(beep0), .tone_idx(tone0),
        .matrix_data(mat0), .numbers_data(num0)
    );

    self_test_seq #(.PHASE_CYCLES(PC), .NUM_STEPS(NS), .PIXELS(PIX), .DIGITS(DIG), .LOOP(1)) dut1 (
        .clk(clk), .sw(sw), .restart(restart), .hold(hold),
        .finish(fin1), .beep_en(beep1), .tone_idx(tone1),
        .matrix_data(mat1), .numbers_data(num1)
    );

    // Outputs as a function of "idle" and elapsed RUN time t since the sequence started
    function automatic outs_t modelOut(bit idle, int t, int loopMode);
        outs_t r;
        int tt, stp, ph;
        bit lit;
        r.finish  = 1'b0;
        r.beep    = 1'b0;
        r.tone    = 3'd0;
        r.matrix  = '0;
        r.numbers = {DIG{4'hf}};
        if (!idle) begin
            if (loopMode == 0 && t >= TOTAL) begin
                r.finish = 1'b1;
            end else begin
                tt  = t % TOTAL;
                stp = tt / (2 * PC);
                ph  = tt % (2 * PC);
                lit = (ph < PC);
                r.tone = 3'(stp);
                r.beep = lit;
                if (lit) begin
                    for (int p = 0; p < PIX; p++) r.matrix[2*p +: 2] = colorTab[stp];
                    r.numbers = {DIG{4'h8}};
                end
                r.finish = (loopMode == 1) && (tt == TOTAL - 1);
            end
        end
        return r;
    endfunction

    // Advance elapsed time by one clock using the inputs seen at that edge
    task automatic advanceModel();
        for (int l = 0; l < 2; l++) begin
            if (!pSw) begin
                idleM[l] = 1'b1;
                tM[l] = 0;
            end else if (pRs) begin
                idleM[l] = 1'b0;
                tM[l] = 0;
            end else if (pHd) begin
                tM[l] = tM[l];
            end else if (idleM[l]) begin
                idleM[l] = 1'b0;
                tM[l] = 0;
            end else if (l == 1) begin
                tM[l] = (tM[l] + 1) % TOTAL;
            end else if (tM[l] < TOTAL) begin
                tM[l] = tM[l] + 1;
            end
        end
    endtask

    task automatic pushExpected();
        exp_t e;
        e.e0 = modelOut(idleM[0], tM[0], 0);
        e.e1 = modelOut(idleM[1], tM[1], 1);
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input bit s, input bit r, input bit h, input int n);
        repeat (n) begin
            @(posedge clk);
            advanceModel();
            #1;
            sw = s;
            restart = r;
            hold = h;
            pSw = s;
            pRs = r;
            pHd = h;
            if (!s) begin
                for (int l = 0; l < 2; l++) begin
                    idleM[l] = 1'b1;
                    tM[l] = 0;
                end
            end
            pushExpected();
        end
    endtask

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: on every falling edge compare both instances against the oldest prediction
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("finish0",  128'(fin0),  128'(e.e0.finish));
                checkOutput("beep0",    128'(beep0), 128'(e.e0.beep));
                checkOutput("tone0",    128'(tone0), 128'(e.e0.tone));
                checkOutput("matrix0",  128'(mat0),  128'(e.e0.matrix));
                checkOutput("numbers0", 128'(num0),  128'(e.e0.numbers));
                checkOutput("finish1",  128'(fin1),  128'(e.e1.finish));
                checkOutput("beep1",    128'(beep1), 128'(e.e1.beep));
                checkOutput("tone1",    128'(tone1), 128'(e.e1.tone));
                checkOutput("matrix1",  128'(mat1),  128'(e.e1.matrix));
                checkOutput("numbers1", 128'(num1),  128'(e.e1.numbers));
            end
        end
    end

    // Directed scenarios followed by randomized switch/restart/hold traffic
    initial begin
        $display("[TB] start");
        applyStimulus(1'b0, 1'b0, 1'b0, 3);
        applyStimulus(1'b1, 1'b0, 1'b0, 140);

        applyStimulus(1'b1, 1'b1, 1'b0, 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 10);
        applyStimulus(1'b1, 1'b0, 1'b1, 10);
        applyStimulus(1'b1, 1'b0, 1'b0, 40);

        applyStimulus(1'b1, 1'b1, 1'b0, 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 18);
        applyStimulus(1'b1, 1'b1, 1'b1, 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 80);

        applyStimulus(1'b1, 1'b1, 1'b0, 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 10);
        applyStimulus(1'b0, 1'b0, 1'b0, 2);
        applyStimulus(1'b1, 1'b0, 1'b0, 30);

        for (int i = 0; i < 1500; i++) begin
            applyStimulus($urandom_range(99) >= 2,
                          $urandom_range(99) < 3,
                          $urandom_range(99) < 15, 1);
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("queueDrained", 128'(expQ.size()), 128'(0));
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/self_test_seq.md
SELF_TEST_SEQ -- requirements
Module: self_test_seq

Interface
REQ-001 The block SHALL have a parameter PHASE_CYCLES, default 25_000_000, giving clk cycles per blink half-period (1 Hz at 50 MHz).
REQ-002 The block SHALL have a parameter NUM_STEPS, default 3, giving the number of test steps (range 1..8).
REQ-003 The block SHALL have a parameter COLOR_SEQ, default 6'b11_01_10, packing 2 bits {R,G} per step with step 0 in the LSBs (red, green, yellow).
REQ-004 The block SHALL have a parameter PIXELS, default 64, giving the matrix pixel count.
REQ-005 The block SHALL have a parameter DIGITS, default 8, giving the display digit count.
REQ-006 The block SHALL have a parameter LOOP, default 0; when 1, the block repeats the sequence forever.
REQ-007 Port clk, input, 1 bit: the single system clock, all logic on the rising edge.
REQ-008 Port sw, input, 1 bit: main switch, used as an asynchronous active-low reset.
REQ-009 Port restart, input, 1 bit: synchronous single-cycle request to rerun from step 0.
REQ-010 Port hold, input, 1 bit: synchronous level input that freezes sequencing.
REQ-011 Port finish, output, 1 bit: self-test complete.
REQ-012 Port beep_en, output, 1 bit: buzzer enable.
REQ-013 Port tone_idx, output, 3 bits: current step number, used to select the buzzer tone.
REQ-014 Port matrix_data, output, 2*PIXELS bits: {R,G} data for every pixel.
REQ-015 Port numbers_data, output, 4*DIGITS bits: one nibble per digit (4'h8 = all segments lit, 4'hf = blank).

Function
REQ-016 The block SHALL implement the states IDLE, RUN and DONE, with transitions IDLE->RUN unconditionally on the next clk.
REQ-017 In RUN, phase counter pc (width clog2(2*PHASE_CYCLES)) SHALL increment each clk, and blink SHALL be 1 when pc<PHASE_CYCLES, else 0.
REQ-018 When pc==2*PHASE_CYCLES-1, pc SHALL clear and step SHALL advance.
REQ-019 When the last step (NUM_STEPS-1) ends, the state SHALL go to DONE if LOOP=0; if LOOP=1 it SHALL stay in RUN at step 0.
REQ-020 In RUN, matrix_data SHALL equal PIXELS copies of COLOR_SEQ[2*step+:2] AND {blink,blink}; outside RUN it SHALL be all zeros.
REQ-021 Every digit nibble SHALL be 4'h8 when in RUN with blink=1, and 4'hf otherwise.
REQ-022 beep_en SHALL equal (RUN AND blink), and tone_idx SHALL equal step, zero-extended.
REQ-023 With LOOP=0, finish SHALL be 1 in DONE and stay until reset or restart; with LOOP=1, finish SHALL pulse for one clk on each wrap to step 0.
REQ-024 While hold=1, pc, step and state SHALL freeze, and outputs SHALL keep their values.
REQ-025 A restart in any state SHALL, on the next clk, give RUN, step 0, pc 0 and finish 0; restart SHALL take priority over hold and over a step advance in the same cycle.
REQ-026 All outputs SHALL decode combinationally from the state, step and pc registers only, with no extra latency.

Reset
REQ-027 While sw=0, the block SHALL force state IDLE, step 0 and pc 0, giving finish 0, beep_en 0, tone_idx 0, matrix_data 0 and numbers_data all-4'hf.
REQ-028 An sw deassertion mid-run SHALL abort the sequence, and on release the sequence SHALL restart from IDLE.

Structure
REQ-029 The state encoding, COLOR_RED/GREEN/YELLOW/OFF constants and DIGIT_ALL/DIGIT_BLANK nibbles SHALL live in shared package selftest_pkg.
REQ-030 The pc counter and blink/end-of-step decode SHALL be sub-module phase_timer (inputs clk, sw, clr, en; outputs blink, step_end).

Verification (PHASE_CYCLES=4, NUM_STEPS=3, defaults otherwise)
REQ-031 Release sw -> 1 clk IDLE, then matrix 2'b10 x64 and numbers 0x88888888 with beep_en=1 for 4 clk, then matrix 0 and numbers 0xffffffff for 4 clk.
REQ-032 Free run -> steps 0/1/2 show colours 10/01/11; at RUN cycle 24, finish=1 with all outputs blank, held for 100 clk.
REQ-033 Assert hold for 10 clk at step 1, pc 2 -> outputs frozen; finish is delayed to RUN cycle 34.
REQ-034 Assert restart and hold together at step 2 -> next clk step 0, pc 0, matrix 2'b10; with LOOP=1, free run gives a finish pulse every 24 clk and never reaches DONE.
REQ-035 Drop sw at step 1 -> outputs reach reset values immediately, without a clk; release -> sequence restarts at step 0.
